// File: rtl/boot_pkg.sv
// Shared types for the boot loader: FSM state encoding and length-byte decoding.
package boot_pkg;

  typedef enum logic [2:0] {
    StLen    = 3'd0,
    StData   = 3'd1,
    StSetup  = 3'd2,
    StStrobe = 3'd3,
    StCsum   = 3'd4,
    StDone   = 3'd5,
    StError  = 3'd6
  } boot_state_e;

  // A length byte of zero encodes a full 256-byte image.
  localparam bit LenZeroMeans256 = 1'b1;

  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    if (LenZeroMeans256 && (len == 8'd0)) begin
      return 9'd256;
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/bus_mux.sv
// Memory bus select: loader registers while loading, ctrl's bus once the load is done.
module bus_mux (
  input  logic       sel_ctrl_i,
  input  logic [7:0] ld_address_i,
  input  logic [7:0] ld_to_mem_i,
  input  logic       ld_mem_clock_i,
  input  logic       ld_mem_write_i,
  input  logic [7:0] ctrl_address_i,
  input  logic [7:0] ctrl_to_mem_i,
  input  logic       ctrl_mem_clock_i,
  input  logic       ctrl_mem_write_i,
  output logic [7:0] address_o,
  output logic [7:0] to_mem_o,
  output logic       mem_clock_o,
  output logic       mem_write_o
);

  always_comb begin
    if (sel_ctrl_i) begin
      address_o   = ctrl_address_i;
      to_mem_o    = ctrl_to_mem_i;
      mem_clock_o = ctrl_mem_clock_i;
      mem_write_o = ctrl_mem_write_i;
    end else begin
      address_o   = ld_address_i;
      to_mem_o    = ld_to_mem_i;
      mem_clock_o = ld_mem_clock_i;
      mem_write_o = ld_mem_write_i;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, checksummed byte stream into memory, then hands the bus to ctrl.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] ctrl_address,
  input  logic [7:0] ctrl_to_mem,
  input  logic       ctrl_mem_clock,
  input  logic       ctrl_mem_write,
  output logic [7:0] address,
  output logic [7:0] to_mem,
  output logic       mem_clock,
  output logic       mem_write,
  output logic       ctrl_run,
  output logic       load_error
);

  boot_state_e state_q, state_d;
  logic [8:0]  count_q, count_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  address_q, address_d;
  logic [7:0]  to_mem_q, to_mem_d;
  logic        mem_clock_q, mem_clock_d;
  logic        mem_write_q, mem_write_d;
  logic        accept;

  assign in_ready   = reset_n &&
                      ((state_q == StLen) || (state_q == StData) || (state_q == StCsum));
  assign accept     = in_valid && in_ready;
  assign ctrl_run   = (state_q == StDone);
  assign load_error = (state_q == StError);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    address_d   = address_q;
    to_mem_d    = to_mem_q;
    mem_clock_d = mem_clock_q;
    mem_write_d = mem_write_q;
    unique case (state_q)
      StLen: begin
        if (accept) begin
          count_d = len_to_count(in_data);
          sum_d   = 8'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          to_mem_d    = in_data;
          sum_d       = sum_q + in_data;
          mem_write_d = 1'b1;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        mem_clock_d = 1'b1;
        state_d     = StStrobe;
      end
      StStrobe: begin
        mem_clock_d = 1'b0;
        mem_write_d = 1'b0;
        address_d   = address_q + 8'd1;
        count_d     = count_q - 9'd1;
        state_d     = (count_q == 9'd1) ? StCsum : StData;
      end
      StCsum: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? StDone : StError;
        end
      end
      StDone, StError: begin
        state_d = state_q;
      end
      default: begin
        state_d = StLen;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StLen;
      count_q     <= 9'd0;
      sum_q       <= 8'd0;
      address_q   <= BASE_ADDR;
      to_mem_q    <= 8'd0;
      mem_clock_q <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      address_q   <= address_d;
      to_mem_q    <= to_mem_d;
      mem_clock_q <= mem_clock_d;
      mem_write_q <= mem_write_d;
    end
  end

  bus_mux u_bus_mux (
    .sel_ctrl_i       (state_q == StDone),
    .ld_address_i     (address_q),
    .ld_to_mem_i      (to_mem_q),
    .ld_mem_clock_i   (mem_clock_q),
    .ld_mem_write_i   (mem_write_q),
    .ctrl_address_i   (ctrl_address),
    .ctrl_to_mem_i    (ctrl_to_mem),
    .ctrl_mem_clock_i (ctrl_mem_clock),
    .ctrl_mem_write_i (ctrl_mem_write),
    .address_o        (address),
    .to_mem_o         (to_mem),
    .mem_clock_o      (mem_clock),
    .mem_write_o      (mem_write)
  );

endmodule
